lpf_coeff_reload_ctrl: RTL and testbench

//  Sequences run-time coefficient reload of the decimate+LPF IQ chain. Host writes coeffs into local RAM; on commit,

---
 rtl/lpf_coeff_reload_ctrl_pkg.sv | 8 +
 rtl/lpf_coeff_reload_ctrl_ram.sv | 20 ++
 rtl/lpf_coeff_reload_ctrl.sv | 83 ++++++++
 tb/tb_lpf_coeff_reload_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lpf_coeff_reload_ctrl_pkg.sv
// lpf_coeff_reload_ctrl_pkg: shared FSM encoding and sizing helper for the coefficient reload controller
package lpf_coeff_reload_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, RELOAD = 2'd2, FLUSH = 2'd3} state_t;
  // Symmetric FIRs only need the first half of the taps (odd counts include the centre tap).
  function automatic int nsend(input int num_coeffs, input bit symmetric);
    return symmetric ? (num_coeffs + 1) / 2 : num_coeffs;
  endfunction
endpackage

// File: rtl/lpf_coeff_reload_ctrl_ram.sv
// lpf_coeff_ram: simple dual-port coefficient store, one write port and one registered read port
module lpf_coeff_ram #(
  parameter int CW = 16,
  parameter int DEPTH = 128,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [CW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [CW-1:0] rdata
);
  logic [CW-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  // Only the read register is reset; stored coefficients survive reset and clear.
  always_ff @(posedge clk) rdata <= rst ? '0 : re ? mem[raddr] : rdata;
endmodule

// File: rtl/lpf_coeff_reload_ctrl.sv
// lpf_coeff_reload_ctrl: gates the IQ chain, waits for drain, streams RAM coefficients to the FIR reload port, then clears the chain
module lpf_coeff_reload_ctrl
  import lpf_coeff_reload_ctrl_pkg::*;
#(
  parameter int COEFF_WIDTH = 16,
  parameter int NUM_COEFFS = 128,
  parameter bit SYMMETRIC_COEFFS = 1'b1,
  parameter int DRAIN_CYCLES = 16,
  localparam int AW = $clog2(NUM_COEFFS),
  localparam int CW = COEFF_WIDTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          wr_stb,
  input  logic [AW-1:0] wr_addr,
  input  logic [CW-1:0] wr_data,
  input  logic          commit,
  input  logic          dp_busy,
  output logic          in_gate,
  output logic          dp_clear,
  output logic [CW-1:0] coeff_out,
  output logic          reload_tvalid,
  output logic          reload_tlast,
  output logic          busy,
  output logic          done,
  output logic          wr_err
);
  localparam int NSEND = nsend(NUM_COEFFS, SYMMETRIC_COEFFS);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [AW-1:0] LAST_BEAT = AW'(NSEND - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [AW:0] DEPTH = (AW + 1)'(NUM_COEFFS);
  state_t state, state_next;
  logic [DW-1:0] drain_cnt;
  logic [AW-1:0] beat;
  logic pending, rd_en, wr_ok, rst;
  assign rst = reset | clear;
  always_ff @(posedge clk) state <= rst ? IDLE : state_next;
  // RELOAD ends on the cycle the final beat is presented, one cycle after its read was issued.
  always_comb begin
    state_next = (state == IDLE)   ? ((commit || pending) ? DRAIN : IDLE)
               : (state == DRAIN)  ? ((!dp_busy && drain_cnt == DRAIN_LAST) ? RELOAD : DRAIN)
               : (state == RELOAD) ? (reload_tlast ? FLUSH : RELOAD)
               :                     ((commit || pending) ? DRAIN : IDLE);
  end
  always_comb begin
    busy = state != IDLE;
    dp_clear = state == FLUSH;
    done = state == FLUSH;
    rd_en = state == RELOAD && !reload_tlast;
    wr_ok = wr_stb && state != RELOAD && {1'b0, wr_addr} < DEPTH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
      beat <= '0;
      pending <= 1'b0;
      in_gate <= 1'b0;
      reload_tvalid <= 1'b0;
      reload_tlast <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      drain_cnt <= (state == DRAIN && !dp_busy) ? drain_cnt + 1'b1 : '0;
      beat <= (!rd_en || beat == LAST_BEAT) ? '0 : beat + 1'b1;
      pending <= (state == DRAIN || state == RELOAD) && (pending || commit);
      in_gate <= state != IDLE || state_next != IDLE;
      reload_tvalid <= rd_en;
      reload_tlast <= rd_en && beat == LAST_BEAT;
      wr_err <= wr_stb && !wr_ok;
    end
  end
  lpf_coeff_ram #(.CW(CW), .DEPTH(NUM_COEFFS), .AW(AW)) ram (
    .clk(clk),
    .rst(rst),
    .we(wr_ok),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re(rd_en),
    .raddr(beat),
    .rdata(coeff_out)
  );
endmodule

// File: tb/tb_lpf_coeff_reload_ctrl.sv
// tb_lpf_coeff_reload_ctrl: directed bench with a beat scoreboard for the coefficient reload controller
module tb_lpf_coeff_reload_ctrl;
  localparam int CW = 16, N = 7, D = 4, NS = 4, AW = 3;
  typedef struct packed {logic [CW-1:0] data; logic last;} beat_t;
  logic clk = 1'b0;
  logic reset, clear, wr_stb, commit, dp_busy;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data, coeff_out;
  logic in_gate, dp_clear, reload_tvalid, reload_tlast, busy, done, wr_err;
  logic [CW-1:0] model [N];
  logic [7:0] pat;
  beat_t exp_q[$];
  beat_t e;
  int checks = 0, failures = 0, done_cnt = 0, dc0;

  always #5 clk = ~clk;

  lpf_coeff_reload_ctrl #(.COEFF_WIDTH(CW), .NUM_COEFFS(N), .SYMMETRIC_COEFFS(1'b1), .DRAIN_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .dp_busy(dp_busy), .in_gate(in_gate), .dp_clear(dp_clear), .coeff_out(coeff_out),
    .reload_tvalid(reload_tvalid), .reload_tlast(reload_tlast), .busy(busy), .done(done), .wr_err(wr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_reload();
    for (int k = 0; k < NS; k++) exp_q.push_back(beat_t'{model[k[AW-1:0]], k == NS - 1});
  endtask

  task automatic write(input int a, input logic [CW-1:0] d);
    wr_stb = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    step();
    wr_stb = 1'b0;
    chk("wr_err_idle", 32'(wr_err), 32'(a >= N));
    if (a < N) model[a[AW-1:0]] = d;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    step();
    commit = 1'b0;
  endtask

  task automatic wait_tvalid();
    int n = 0;
    while (!reload_tvalid && n < 60) begin
      step();
      n++;
    end
    chk("tvalid_timeout", 32'(reload_tvalid), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk("done_timeout", 32'(done), 1);
  endtask

  // Scoreboard: every presented beat must match the oldest queued expectation.
  always @(negedge clk) if (!reset) begin
    if (done) done_cnt++;
    if (reload_tvalid) begin
      chk("beat_queued", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("coeff", 32'(coeff_out), 32'(e.data));
        chk("tlast", 32'(reload_tlast), 32'(e.last));
      end
    end else chk("tlast_no_valid", 32'(reload_tlast), 0);
  end

  initial begin
    reset = 1'b1; clear = 1'b0; wr_stb = 1'b0; commit = 1'b0; dp_busy = 1'b0;
    wr_addr = '0; wr_data = '0;
    repeat (3) step();
    chk("reset_outs", 32'({in_gate, dp_clear, reload_tvalid, reload_tlast, busy, done, wr_err, coeff_out}), 0);
    reset = 1'b0;
    step();
    for (int k = 0; k < N; k++) write(k, CW'(k + 1));
    push_reload();
    pulse_commit();
    chk("gate_after_commit", 32'(in_gate), 1);
    chk("busy_after_commit", 32'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      chk("drain_no_valid", 32'(reload_tvalid), 0);
      step();
    end
    chk("first_beat_latency", 32'(reload_tvalid), 1);
    wait_done();
    chk("flush_dp_clear", 32'(dp_clear), 1);
    chk("flush_gate", 32'(in_gate), 1);
    step();
    chk("flush_plus1_gate", 32'(in_gate), 1);
    chk("flush_plus1_idle", 32'({busy, done, dp_clear}), 0);
    step();
    chk("gate_released", 32'(in_gate), 0);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_all_beats", exp_q.size(), 0);

    push_reload();
    pulse_commit();
    pat = 8'b1001_0000;
    for (int i = 0; i < 8; i++) begin
      dp_busy = pat[7];
      pat = pat << 1;
      step();
      chk("drain_hold", 32'(reload_tvalid), 0);
    end
    dp_busy = 1'b0;
    step();
    chk("drain_release", 32'(reload_tvalid), 1);
    wait_done();
    repeat (2) step();

    dc0 = done_cnt;
    push_reload();
    push_reload();
    pulse_commit();
    wait_tvalid();
    pulse_commit();
    pulse_commit();
    wait_done();
    step();
    chk("pending_reenter", 32'({busy, in_gate}), 32'b11);
    wait_done();
    repeat (20) step();
    chk("done_twice", done_cnt - dc0, 2);
    chk("idle_after_pending", 32'(busy), 0);
    chk("t4_all_beats", exp_q.size(), 0);

    push_reload();
    pulse_commit();
    wait_tvalid();
    wr_stb = 1'b1; wr_addr = '0; wr_data = 16'hdead;
    step();
    wr_stb = 1'b0;
    chk("wr_err_reload", 32'(wr_err), 1);
    step();
    chk("wr_err_pulse", 32'(wr_err), 0);
    wait_done();
    repeat (2) step();
    write(7, 16'hbeef);
    step();
    chk("wr_err_clears", 32'(wr_err), 0);
    write(1, 16'h1234);
    push_reload();
    pulse_commit();
    wait_done();
    repeat (2) step();
    chk("t5_all_beats", exp_q.size(), 0);

    push_reload();
    pulse_commit();
    wait_tvalid();
    step();
    step();
    dc0 = done_cnt;
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clear_outs", 32'({in_gate, dp_clear, reload_tvalid, reload_tlast, busy, done, wr_err, coeff_out}), 0);
    chk("clear_left_beat", exp_q.size(), 1);
    exp_q.delete();
    repeat (10) step();
    chk("no_done_after_clear", done_cnt, dc0);
    push_reload();
    pulse_commit();
    wait_done();
    repeat (2) step();
    chk("t6_all_beats", exp_q.size(), 0);
    chk("t6_done_once", done_cnt - dc0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
